// File: rtl/vga_raster_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_raster_addr_gen: VGA raster timing with incremental linear address |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module vga_raster_addr_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset,
  output logic        pix_en,
  output logic [18:0] ADDR,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [18:0]   acnt;
  logic          visible;
  logic          line_end;
  logic          frame_end;
  logic          h_sync_win;
  logic          v_sync_win;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          div <= '0;
        end else if (div == DIV_LAST) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pix_en = (div == DIV_LAST);
    end else begin : g_no_div
      assign pix_en = 1'b1;
    end
  endgenerate

  assign visible    = (h < H_VIS) && (v < V_VIS);
  assign line_end   = (h == H_LAST);
  assign frame_end  = line_end && (v == V_LAST);
  assign h_sync_win = (h >= HS_FIRST) && (h <= HS_LAST);
  assign v_sync_win = (v >= VS_FIRST) && (v <= VS_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Address runs only across visible pixels, so it stays continuous line to line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acnt <= '0;
    end else if (pix_en) begin
      if (frame_end) begin
        acnt <= '0;
      end else if (visible) begin
        acnt <= acnt + 19'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ADDR        <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_count <= '0;
    end else if (pix_en) begin
      ADDR     <= visible ? acnt : '0;
      video_on <= visible;
      hsync    <= ~h_sync_win;
      vsync    <= ~v_sync_win;
      if (frame_end) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // One system clock wide whatever the divider ratio
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h == '0) && (v == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_raster_addr_gen.sv
`default_nettype none
// Testbench for vga_raster_addr_gen: full-size timing on line 0/1, reduced
// geometry for frame-level, wrap, mid-frame reset and divider-ratio checks.
module tb_vga_raster_addr_gen;

  logic clock;
  logic reset;

  // Full-size, CLK_DIV=2
  logic        a_pix, a_vo, a_hs, a_vs, a_fs;
  logic [18:0] a_addr;
  logic [7:0]  a_fc;
  // Small geometry 12x8 (6x4 visible), CLK_DIV=2 and CLK_DIV=1
  logic        b_pix, b_vo, b_hs, b_vs, b_fs;
  logic [18:0] b_addr;
  logic [7:0]  b_fc;
  logic        c_pix, c_vo, c_hs, c_vs, c_fs;
  logic [18:0] c_addr;
  logic [7:0]  c_fc;

  vga_raster_addr_gen u_a (
    .clock(clock), .reset(reset), .pix_en(a_pix), .ADDR(a_addr), .video_on(a_vo),
    .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_raster_addr_gen #(
    .CLK_DIV(2), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clock(clock), .reset(reset), .pix_en(b_pix), .ADDR(b_addr), .video_on(b_vo),
    .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_raster_addr_gen #(
    .CLK_DIV(1), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_c (
    .clock(clock), .reset(reset), .pix_en(c_pix), .ADDR(c_addr), .video_on(c_vo),
    .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs), .frame_count(c_fc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int k;
    int addr;
    int vo;
    int hs;
    int vs;
    int fs;
  } vec_t;

  vec_t tbl [12];
  int   applied;
  int   miscompares;
  int   edges;
  int   bad_b, bad_b2, bad_c;
  int   vis, maxa, vs_low, hs_low, c_pix_low;
  int   b_fsq [$];
  int   c_fsq [$];

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edges++;
  endtask

  task automatic chk_rst(input string tag, input logic [18:0] addr, input logic vo,
                         input logic hs, input logic vs, input logic fs,
                         input logic [7:0] fc);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_video_on"}, int'(vo), 0);
    chk({tag, "_hsync"}, int'(hs), 1);
    chk({tag, "_vsync"}, int'(vs), 1);
    chk({tag, "_frame_start"}, int'(fs), 0);
    chk({tag, "_frame_count"}, int'(fc), 0);
  endtask

  // Reference for the 12x8 geometry: pixel k of the frame, row-major
  function automatic int m_addr(input int k);
    int x, y;
    x = k % 12;
    y = (k / 12) % 8;
    return (x < 6 && y < 4) ? x + 6 * y : 0;
  endfunction
  function automatic int m_vo(input int k);
    return ((k % 12) < 6 && ((k / 12) % 8) < 4) ? 1 : 0;
  endfunction
  function automatic int m_hs(input int k);
    return ((k % 12) >= 8 && (k % 12) <= 10) ? 0 : 1;
  endfunction
  function automatic int m_vs(input int k);
    return (((k / 12) % 8) >= 5 && ((k / 12) % 8) <= 6) ? 0 : 1;
  endfunction

  function automatic bit b_ok(input int k);
    return int'(b_addr) == m_addr(k) && int'(b_vo) == m_vo(k) &&
           int'(b_hs) == m_hs(k) && int'(b_vs) == m_vs(k);
  endfunction
  function automatic bit c_ok(input int k);
    return int'(c_addr) == m_addr(k) && int'(c_vo) == m_vo(k) &&
           int'(c_hs) == m_hs(k) && int'(c_vs) == m_vs(k);
  endfunction

  initial begin
    applied     = 0;
    miscompares = 0;
    edges       = 0;
    bad_b = 0; bad_b2 = 0; bad_c = 0;
    vis = 0; maxa = 0; vs_low = 0; hs_low = 0; c_pix_low = 0;

    //           k     addr  vo hs vs fs
    tbl[0]  = '{   0,    0, 1, 1, 1, 1};
    tbl[1]  = '{   1,    1, 1, 1, 1, 0};
    tbl[2]  = '{ 639,  639, 1, 1, 1, 0};
    tbl[3]  = '{ 640,    0, 0, 1, 1, 0};
    tbl[4]  = '{ 655,    0, 0, 1, 1, 0};
    tbl[5]  = '{ 656,    0, 0, 0, 1, 0};
    tbl[6]  = '{ 751,    0, 0, 0, 1, 0};
    tbl[7]  = '{ 752,    0, 0, 1, 1, 0};
    tbl[8]  = '{ 799,    0, 0, 1, 1, 0};
    tbl[9]  = '{ 800,  640, 1, 1, 1, 0};
    tbl[10] = '{1439, 1279, 1, 1, 1, 0};
    tbl[11] = '{1440,    0, 0, 1, 1, 0};

    // ---- Reset state and full-size line 0 / line 1 ----
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_rst("a_rst", a_addr, a_vo, a_hs, a_vs, a_fs, a_fc);
    chk("a_rst_pix_en", int'(a_pix), 0);
    reset = 1'b0;
    edges = 0;

    step();
    chk("a_pix_en_edge1", int'(a_pix), 1);
    chk("a_addr_edge1", int'(a_addr), 0);
    chk("a_video_on_edge1", int'(a_vo), 0);
    chk("a_frame_start_edge1", int'(a_fs), 0);

    for (int i = 0; i < 12; i++) begin
      while (edges < 2 * (tbl[i].k + 1)) step();
      chk($sformatf("a_addr_k%0d", tbl[i].k), int'(a_addr), tbl[i].addr);
      chk($sformatf("a_video_on_k%0d", tbl[i].k), int'(a_vo), tbl[i].vo);
      chk($sformatf("a_hsync_k%0d", tbl[i].k), int'(a_hs), tbl[i].hs);
      chk($sformatf("a_vsync_k%0d", tbl[i].k), int'(a_vs), tbl[i].vs);
      chk($sformatf("a_frame_start_k%0d", tbl[i].k), int'(a_fs), tbl[i].fs);
      if (i == 0) begin
        chk("a_pix_en_after_tick", int'(a_pix), 0);
        step();
        chk("a_frame_start_width", int'(a_fs), 0);
        chk("a_addr_hold", int'(a_addr), 0);
        chk("a_video_on_hold", int'(a_vo), 1);
      end
    end
    chk("a_frame_count_line1", int'(a_fc), 0);

    // ---- Reduced geometry: frame stats, 256-frame wrap, CLK_DIV=1 ----
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    edges = 0;
    for (int e = 1; e <= 49344; e++) begin
      step();
      if (c_pix !== 1'b1) c_pix_low++;
      if (b_fs === 1'b1 && b_fsq.size() < 3) b_fsq.push_back(e);
      if (c_fs === 1'b1 && c_fsq.size() < 3) c_fsq.push_back(e);
      if (e <= 96 && !c_ok(e - 1)) bad_c++;
      if (e % 2 == 0 && e <= 192) begin
        if (!b_ok(e / 2 - 1)) bad_b++;
        if (b_vo === 1'b1) vis++;
        if (int'(b_addr) > maxa) maxa = int'(b_addr);
        if (b_vs === 1'b0) vs_low++;
        if (b_hs === 1'b0) hs_low++;
      end
      if (e % 2 == 0 && e >= 49154 && !b_ok(e / 2 - 1)) bad_b2++;
      case (e)
        3:     chk("b_frame_start_width", int'(b_fs), 0);
        95:    chk("c_frame_count_pre1", int'(c_fc), 0);
        96:    chk("c_frame_count_1", int'(c_fc), 1);
        190:   chk("b_frame_count_pre1", int'(b_fc), 0);
        192:   chk("b_frame_count_1", int'(b_fc), 1);
        24575: chk("c_frame_count_255", int'(c_fc), 255);
        24576: chk("c_frame_count_wrap", int'(c_fc), 0);
        49150: chk("b_frame_count_255", int'(b_fc), 255);
        49152: chk("b_frame_count_wrap", int'(b_fc), 0);
        49154: chk("b_frame_start_f257", int'(b_fs), 1);
        49155: chk("b_frame_start_f257_width", int'(b_fs), 0);
        default: ;
      endcase
    end
    chk("b_seq_frame1_errors", bad_b, 0);
    chk("b_seq_frame257_errors", bad_b2, 0);
    chk("c_seq_frame1_errors", bad_c, 0);
    chk("b_visible_ticks", vis, 24);
    chk("b_addr_max", maxa, 23);
    chk("b_vsync_low_ticks", vs_low, 24);
    chk("b_hsync_low_ticks", hs_low, 24);
    chk("c_pix_en_low_edges", c_pix_low, 0);
    chk("b_fs_count", b_fsq.size(), 3);
    chk("c_fs_count", c_fsq.size(), 3);
    if (b_fsq.size() == 3) begin
      chk("b_fs_first_edge", b_fsq[0], 2);
      chk("b_fs_period1", b_fsq[1] - b_fsq[0], 192);
      chk("b_fs_period2", b_fsq[2] - b_fsq[1], 192);
    end
    if (c_fsq.size() == 3) begin
      chk("c_fs_first_edge", c_fsq[0], 1);
      chk("c_fs_period1", c_fsq[1] - c_fsq[0], 96);
      chk("c_fs_period2", c_fsq[2] - c_fsq[1], 96);
    end

    // ---- Reset asserted mid-frame, between clock edges ----
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    edges = 0;
    while (edges < 56) step();
    chk("b_addr_pre_reset", int'(b_addr), 15);
    chk("b_video_on_pre_reset", int'(b_vo), 1);
    chk("a_addr_pre_reset", int'(a_addr), 27);
    #2;
    reset = 1'b1;
    #1;
    chk_rst("b_async_rst", b_addr, b_vo, b_hs, b_vs, b_fs, b_fc);
    chk_rst("a_async_rst", a_addr, a_vo, a_hs, a_vs, a_fs, a_fc);
    chk("b_async_rst_pix_en", int'(b_pix), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    edges = 0;
    step();
    chk("b_restart_edge1_fs", int'(b_fs), 0);
    chk("b_restart_edge1_pix_en", int'(b_pix), 1);
    step();
    chk("b_restart_addr", int'(b_addr), 0);
    chk("b_restart_video_on", int'(b_vo), 1);
    chk("b_restart_frame_start", int'(b_fs), 1);
    step();
    chk("b_restart_fs_clear", int'(b_fs), 0);
    step();
    chk("b_restart_addr_next", int'(b_addr), 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
